msx_bus_cycle: RTL and testbench
================================

// Module: msx_bus_cycle
// PURPOSE
//  Consumes the debounced MSX slot strobes, address and data produced by the GPIO pin filters.
//  Detects and classifies each bus cycle (mem rd/wr in our slot, I/O rd/wr), then latches address/data.
//  Presents one req/ack transaction per bus cycle to the internal fabric.
//  Drives read data back onto the slot with output enable and optional /WAIT stretching.
// PARAMETERS
//  SETTLE_CYCLES  2     ena-qualified samples a strobe must stay asserted before latching (1..15)
//  TIMEOUT        255   clk cycles in REQ without ack before abort (1..255)
//  WAIT_EN        1'b1  1: hold wait_n low while a read is unserviced
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   async active-low reset
//  ena          in   1   sample enable, same strobe the pin filters use
//  sltsl_n      in   1   filtered slot select (idle 1)
//  mreq_n       in   1   filtered /MREQ
//  iorq_n       in   1   filtered /IORQ
//  rd_n         in   1   filtered /RD
//  wr_n         in   1   filtered /WR
//  m1_n         in   1   filtered /M1
//  addr         in   16  filtered address bus
//  din          in   8   filtered data bus
//  req          out  1   transaction request, held until ack or timeout
//  req_wr       out  1   1 = write, 0 = read; stable while req
//  req_io       out  1   1 = I/O space, 0 = memory; stable while req
//  req_addr     out  16  latched address; stable while req
//  req_wdata    out  8   latched write data; stable while req
//  ack          in   1   single-clk completion from fabric
//  rdata        in   8   read data, valid with ack
//  dout         out  8   data driven to slot
//  dout_oe      out  1   slot data output enable
//  wait_n       out  1   to slot /WAIT, active low
//  timeout_err  out  1   one-clk pulse on REQ timeout
// BEHAVIOUR
//  - Reset: state IDLE; req, req_wr, req_io, dout_oe, timeout_err = 0; req_addr, req_wdata, dout = 0; wait_n = 1.
//  - Reset mid-cycle aborts immediately; no req is re-issued for that bus cycle.
//  - Valid cycle: exactly one of rd_n/wr_n low, and one of the following:
//      * iorq_n low with m1_n high (I/O cycle)
//      * mreq_n low with sltsl_n low (memory cycle in our slot)
//  - Cycles that do not qualify: INTA (m1_n & iorq_n both low), rd_n & wr_n both low, and mreq_n & iorq_n both low.
//    These are ignored and the block stays in IDLE.
//  - IDLE -> SETTLE on a valid cycle; the settle counter is cleared.
//  - SETTLE: count ena cycles in which the same classification holds.
//      * Classification drops or changes: abort to IDLE, with no req and no error.
//      * Count reaches SETTLE_CYCLES: latch addr/din/type, req=1 on the next clk, go to REQ.
//  - REQ: req and fields held; ack is ignored outside REQ.
//      * ack=1: req=0 in the same edge. For reads, dout<=rdata and dout_oe=1 if the read strobe is still low. Go to HOLD.
//      * Timeout counter (clk-based, starts at req rise) reaches TIMEOUT: req=0, timeout_err pulse, dout_oe stays 0, go to HOLD.
//      * Strobe released during REQ: the transaction still completes (a write must commit). After ack, skip dout_oe and go to HOLD.
//  - HOLD: wait for rd_n & wr_n both 1 (sampled every clk, not gated by ena).
//      * On that clk dout_oe=0 and the state returns to IDLE.
//      * A back-to-back new cycle starts SETTLE no earlier than the next clk.
//  - wait_n (WAIT_EN=1): low from SETTLE entry of a read until ack or timeout, then 1. Always 1 for writes and when WAIT_EN=0.
//  - Latency: req rises SETTLE_CYCLES ena pulses + 1 clk after the qualifying sample.
//  - dout_oe rises 1 clk after ack.
//  - timeout counter is 8-bit saturating; the settle counter is 4-bit.
// STRUCTURE
//  - msx_bus_pkg holds:
//      * state enum (IDLE, SETTLE, REQ, HOLD)
//      * cycle_t struct {wr, io}
//      * classify function
//      * Z80 strobe polarity constants
//  - Single module, no sub-module; all counters are inline.
// TESTING
//  - Mem read: sltsl_n=mreq_n=rd_n=0, addr=16'h4000, ena every clk, ack after 5 clk with rdata=8'hA5.
//    -> req 3 clk after qualify with req_wr=0, req_io=0; wait_n low until ack; dout=8'hA5 and dout_oe=1 one clk after ack; dout_oe=0 on rd_n release.
//  - I/O write: iorq_n=wr_n=0, addr=16'h0098, din=8'h3C.
//    -> req_io=1, req_wr=1, req_wdata=8'h3C; wait_n stays 1; dout_oe never asserts.
//  - Glitch: rd_n low for 1 ena sample only -> no req; state returns to IDLE.
//  - INTA (m1_n=iorq_n=0) and mreq_n=0 with sltsl_n=1 -> no req.
//  - No ack with TIMEOUT=16 -> req drops after 16 clk; timeout_err one pulse; wait_n=1; dout_oe=0.
//  - reset_n low during REQ -> all outputs at reset values asynchronously; no req after release until a new cycle.

Source files
------------

// File: rtl/msx_bus_pkg.sv
// Shared types and helpers for the MSX slot bus-cycle bridge.
package msx_bus_pkg;

    // Z80 bus strobes are active low.
    localparam logic STROBE_ACTIVE = 1'b0;
    localparam logic STROBE_IDLE   = 1'b1;

    // Bus-cycle tracking states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REQ    = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Kind of bus cycle: write vs read, I/O vs memory.
    typedef struct packed {
        logic wr;
        logic io;
    } cycle_t;

    // Result of classifying one strobe sample.
    typedef struct packed {
        logic   valid;
        cycle_t cyc;
    } class_t;

    // Decide whether the current strobes form a cycle this block must serve.
    // Exactly one of RD/WR must be active; I/O cycles must not be interrupt
    // acknowledges (M1 with IORQ); memory cycles must target our slot; MREQ
    // and IORQ together is never a legal combination.
    function automatic class_t classify(
        input logic sltsl_n,
        input logic mreq_n,
        input logic iorq_n,
        input logic rd_n,
        input logic wr_n,
        input logic m1_n
    );
        class_t res;
        logic   rd_act;
        logic   wr_act;
        logic   io_ok;
        logic   mem_ok;
        rd_act  = (rd_n == STROBE_ACTIVE);
        wr_act  = (wr_n == STROBE_ACTIVE);
        io_ok   = (iorq_n == STROBE_ACTIVE) && (m1_n == STROBE_IDLE) &&
                  (mreq_n == STROBE_IDLE);
        mem_ok  = (mreq_n == STROBE_ACTIVE) && (sltsl_n == STROBE_ACTIVE) &&
                  (iorq_n == STROBE_IDLE);
        res.valid  = (rd_act ^ wr_act) && (io_ok || mem_ok);
        res.cyc.wr = wr_act;
        res.cyc.io = io_ok;
        return res;
    endfunction

endpackage

// File: rtl/msx_bus_cycle.sv
// MSX slot bus-cycle detector: classifies slot cycles, turns each into one
// req/ack transaction on the internal fabric, and returns read data to the
// slot with output enable and optional /WAIT stretching.
module msx_bus_cycle
    import msx_bus_pkg::*;
#(
    parameter logic [3:0] SETTLE_CYCLES = 4'd2,
    parameter logic [7:0] TIMEOUT       = 8'd255,
    parameter logic       WAIT_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ena,
    input  logic        sltsl_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    output logic        req,
    output logic        req_wr,
    output logic        req_io,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        ack,
    input  logic [7:0]  rdata,
    output logic [7:0]  dout,
    output logic        dout_oe,
    output logic        wait_n,
    output logic        timeout_err
);

    state_t      r_state;
    logic [3:0]  r_settle_cnt;
    logic [7:0]  r_tmo_cnt;
    cycle_t      r_cls;
    logic        r_armed;
    logic        r_req;
    logic        r_req_wr;
    logic        r_req_io;
    logic [15:0] r_req_addr;
    logic [7:0]  r_req_wdata;
    logic [7:0]  r_dout;
    logic        r_dout_oe;
    logic        r_wait_n;
    logic        r_timeout_err;

    state_t      w_state_nxt;
    logic [3:0]  w_settle_cnt_nxt;
    logic [7:0]  w_tmo_cnt_nxt;
    cycle_t      w_cls_nxt;
    logic        w_armed_nxt;
    logic        w_req_nxt;
    logic        w_req_wr_nxt;
    logic        w_req_io_nxt;
    logic [15:0] w_req_addr_nxt;
    logic [7:0]  w_req_wdata_nxt;
    logic [7:0]  w_dout_nxt;
    logic        w_dout_oe_nxt;
    logic        w_wait_n_nxt;
    logic        w_timeout_err_nxt;

    class_t      w_cls;
    logic        w_strobes_idle;
    logic        w_cls_same;

    // Next-state and next-output computation for the bus-cycle FSM.
    always_comb begin
        w_cls          = classify(sltsl_n, mreq_n, iorq_n, rd_n, wr_n, m1_n);
        w_strobes_idle = (rd_n == STROBE_IDLE) && (wr_n == STROBE_IDLE);
        w_cls_same     = w_cls.valid && (w_cls.cyc == r_cls);

        w_state_nxt       = r_state;
        w_settle_cnt_nxt  = r_settle_cnt;
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_cls_nxt         = r_cls;
        // After reset the block stays disarmed until the slot strobes have
        // been seen idle, so a bus cycle cut by reset is never re-issued.
        w_armed_nxt       = r_armed | w_strobes_idle;
        w_req_nxt         = r_req;
        w_req_wr_nxt      = r_req_wr;
        w_req_io_nxt      = r_req_io;
        w_req_addr_nxt    = r_req_addr;
        w_req_wdata_nxt   = r_req_wdata;
        w_dout_nxt        = r_dout;
        w_dout_oe_nxt     = r_dout_oe;
        w_wait_n_nxt      = r_wait_n;
        w_timeout_err_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (ena && r_armed && w_cls.valid) begin
                    w_state_nxt      = ST_SETTLE;
                    w_settle_cnt_nxt = 4'd0;
                    w_cls_nxt        = w_cls.cyc;
                    // Reads stretch the slot cycle until data is back.
                    w_wait_n_nxt     = ~(WAIT_EN & ~w_cls.cyc.wr);
                end else begin
                    w_state_nxt      = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (r_settle_cnt >= SETTLE_CYCLES) begin
                    w_state_nxt     = ST_REQ;
                    w_req_nxt       = 1'b1;
                    w_req_wr_nxt    = r_cls.wr;
                    w_req_io_nxt    = r_cls.io;
                    w_req_addr_nxt  = addr;
                    w_req_wdata_nxt = din;
                    w_tmo_cnt_nxt   = 8'd0;
                end else if (ena) begin
                    if (w_cls_same) begin
                        w_settle_cnt_nxt = r_settle_cnt + 4'd1;
                    end else begin
                        // Glitch or changed cycle type: drop it silently.
                        w_state_nxt  = ST_IDLE;
                        w_wait_n_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end

            ST_REQ: begin
                if (ack) begin
                    w_req_nxt    = 1'b0;
                    w_wait_n_nxt = 1'b1;
                    w_state_nxt  = ST_HOLD;
                    // Only drive the slot if the CPU is still reading.
                    if (!r_req_wr && (rd_n == STROBE_ACTIVE)) begin
                        w_dout_nxt    = rdata;
                        w_dout_oe_nxt = 1'b1;
                    end else begin
                        w_dout_oe_nxt = 1'b0;
                    end
                end else if (r_tmo_cnt == (TIMEOUT - 8'd1)) begin
                    w_req_nxt         = 1'b0;
                    w_wait_n_nxt      = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = ST_HOLD;
                end else begin
                    w_tmo_cnt_nxt = (r_tmo_cnt == 8'hFF) ? r_tmo_cnt
                                                         : r_tmo_cnt + 8'd1;
                end
            end

            ST_HOLD: begin
                if (w_strobes_idle) begin
                    w_dout_oe_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_state_nxt   = ST_HOLD;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_req_nxt     = 1'b0;
                w_dout_oe_nxt = 1'b0;
                w_wait_n_nxt  = 1'b1;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_settle_cnt  <= 4'd0;
            r_tmo_cnt     <= 8'd0;
            r_cls         <= '{wr: 1'b0, io: 1'b0};
            r_armed       <= 1'b0;
            r_req         <= 1'b0;
            r_req_wr      <= 1'b0;
            r_req_io      <= 1'b0;
            r_req_addr    <= 16'd0;
            r_req_wdata   <= 8'd0;
            r_dout        <= 8'd0;
            r_dout_oe     <= 1'b0;
            r_wait_n      <= 1'b1;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_settle_cnt  <= w_settle_cnt_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_cls         <= w_cls_nxt;
            r_armed       <= w_armed_nxt;
            r_req         <= w_req_nxt;
            r_req_wr      <= w_req_wr_nxt;
            r_req_io      <= w_req_io_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_req_wdata   <= w_req_wdata_nxt;
            r_dout        <= w_dout_nxt;
            r_dout_oe     <= w_dout_oe_nxt;
            r_wait_n      <= w_wait_n_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign req         = r_req;
    assign req_wr      = r_req_wr;
    assign req_io      = r_req_io;
    assign req_addr    = r_req_addr;
    assign req_wdata   = r_req_wdata;
    assign dout        = r_dout;
    assign dout_oe     = r_dout_oe;
    assign wait_n      = r_wait_n;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_msx_bus_cycle.sv
// Directed bench for msx_bus_cycle: each scenario derives its expected
// per-cycle waveform from the cycle timing rules (qualify edge, settle
// length, ack edge, release edge) and a compare process checks every cycle.
module tb_msx_bus_cycle;

    localparam int SETTLE = 2;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ena;
    logic        sltsl_n, mreq_n, iorq_n, rd_n, wr_n, m1_n;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        req, req_wr, req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic [7:0]  dout;
    logic        dout_oe, wait_n, timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    logic        e_req, e_req_wr, e_req_io;
    logic [15:0] e_req_addr;
    logic [7:0]  e_req_wdata, e_dout;
    logic        e_dout_oe, e_wait_n, e_tmo_err;

    int rise_edge, req_cycles, err_pulses, oe_seen;

    msx_bus_cycle #(
        .SETTLE_CYCLES(4'd2),
        .TIMEOUT      (8'd16),
        .WAIT_EN      (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ena        (ena),
        .sltsl_n    (sltsl_n),
        .mreq_n     (mreq_n),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .m1_n       (m1_n),
        .addr       (addr),
        .din        (din),
        .req        (req),
        .req_wr     (req_wr),
        .req_io     (req_io),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .rdata      (rdata),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .wait_n     (wait_n),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req",         32'(req),         32'(e_req));
            check("req_wr",      32'(req_wr),      32'(e_req_wr));
            check("req_io",      32'(req_io),      32'(e_req_io));
            check("req_addr",    32'(req_addr),    32'(e_req_addr));
            check("req_wdata",   32'(req_wdata),   32'(e_req_wdata));
            check("dout",        32'(dout),        32'(e_dout));
            check("dout_oe",     32'(dout_oe),     32'(e_dout_oe));
            check("wait_n",      32'(wait_n),      32'(e_wait_n));
            check("timeout_err", 32'(timeout_err), 32'(e_tmo_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus(input bit active, input bit io, input bit wr);
        m1_n = 1'b1;
        if (active) begin
            sltsl_n = io ? 1'b1 : 1'b0;
            mreq_n  = io ? 1'b1 : 1'b0;
            iorq_n  = io ? 1'b0 : 1'b1;
            rd_n    = wr ? 1'b1 : 1'b0;
            wr_n    = wr ? 1'b0 : 1'b1;
        end else begin
            sltsl_n = 1'b1;
            mreq_n  = 1'b1;
            iorq_n  = 1'b1;
            rd_n    = 1'b1;
            wr_n    = 1'b1;
        end
    endtask

    task automatic set_idle();
        drive_bus(1'b0, 1'b0, 1'b0);
        ena   = 1'b1;
        ack   = 1'b0;
        rdata = 8'h00;
    endtask

    task automatic exp_quiet();
        e_req     = 1'b0;
        e_dout_oe = 1'b0;
        e_wait_n  = 1'b1;
        e_tmo_err = 1'b0;
    endtask

    task automatic exp_reset();
        exp_quiet();
        e_req_wr    = 1'b0;
        e_req_io    = 1'b0;
        e_req_addr  = 16'h0000;
        e_req_wdata = 8'h00;
        e_dout      = 8'h00;
    endtask

    // One complete slot cycle. Edge 0 is the qualifying sample; ena is high
    // on every p-th edge; ack_after = 0 means the fabric never answers;
    // the strobes are released before edge rel.
    task automatic txn(input bit io, input bit wr, input logic [15:0] a,
                       input logic [7:0] d, input int ack_after,
                       input logic [7:0] rd, input int rel, input int p);
        int  rise, e_edge, x_edge;
        bit  acked, rd_cyc, oe_on;
        rise   = SETTLE * p + 1;
        acked  = (ack_after > 0);
        e_edge = acked ? rise + ack_after : rise + TMO;
        rd_cyc = !wr;
        oe_on  = rd_cyc && acked && (rel > e_edge);
        x_edge = (rel > e_edge + 1) ? rel : e_edge + 1;
        rise_edge = -1; req_cycles = 0; err_pulses = 0; oe_seen = 0;
        for (int k = 0; k <= x_edge + 1; k++) begin
            ena   = ((k % p) == 0);
            drive_bus(k < rel, io, wr);
            addr  = a;
            din   = d;
            ack   = acked && (k == e_edge);
            rdata = (k == e_edge) ? rd : 8'h00;
            tick();
            e_req     = (k >= rise) && (k < e_edge);
            e_wait_n  = !(rd_cyc && (k < e_edge));
            e_tmo_err = !acked && (k == e_edge);
            e_dout_oe = oe_on && (k >= e_edge) && (k < x_edge);
            if (k == rise) begin
                e_req_wr    = wr;
                e_req_io    = io;
                e_req_addr  = a;
                e_req_wdata = d;
            end
            if (oe_on && (k == e_edge)) e_dout = rd;
            if (req && rise_edge < 0) rise_edge = k;
            if (req) req_cycles++;
            if (timeout_err) err_pulses++;
            if (dout_oe) oe_seen = 1;
        end
        set_idle();
    endtask

    // Drive a non-qualifying strobe pattern and expect nothing to happen.
    task automatic ignored(input logic s, input logic mq, input logic io,
                           input logic r, input logic w, input logic m1);
        sltsl_n = s; mreq_n = mq; iorq_n = io; rd_n = r; wr_n = w; m1_n = m1;
        addr = 16'h0038;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_quiet();
        end
        set_idle();
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_quiet();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        addr = 16'h0000;
        din  = 8'h00;
        set_idle();
        exp_reset();
        tick(); tick();
        chk_en = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        // Memory read in our slot, ack 5 clk after req.
        txn(1'b0, 1'b0, 16'h4000, 8'h00, 5, 8'hA5, 11, 1);
        check("memrd_req_latency", 32'(rise_edge), 32'd3);
        check("memrd_dout",        32'(dout),      32'h0000_00A5);
        check("memrd_oe_seen",     32'(oe_seen),   32'd1);

        // I/O write.
        txn(1'b1, 1'b1, 16'h0098, 8'h3C, 2, 8'h00, 9, 1);
        check("iowr_wdata",   32'(req_wdata), 32'h0000_003C);
        check("iowr_oe_seen", 32'(oe_seen),   32'd0);

        // Memory write with strobe released at the ack edge, then an
        // I/O read with ena on every other clk.
        txn(1'b0, 1'b1, 16'hC000, 8'h5A, 1, 8'h00, 4, 1);
        txn(1'b1, 1'b0, 16'h00A8, 8'h11, 3, 8'h77, 10, 2);
        check("iord_slow_ena_latency", 32'(rise_edge), 32'd5);
        check("iord_dout",             32'(dout),      32'h0000_0077);

        // Read strobe released during REQ: completes but never drives slot.
        txn(1'b0, 1'b0, 16'h4444, 8'h00, 4, 8'hEE, 5, 1);
        check("early_rel_oe_seen", 32'(oe_seen), 32'd0);

        // No ack: timeout after 16 clk.
        txn(1'b0, 1'b0, 16'h7FFF, 8'h00, 0, 8'h00, 21, 1);
        check("tmo_req_cycles", 32'(req_cycles), 32'd16);
        check("tmo_err_pulses", 32'(err_pulses), 32'd1);
        check("tmo_oe_seen",    32'(oe_seen),    32'd0);

        // ack outside REQ is ignored.
        ack = 1'b1; rdata = 8'hFF;
        tick(); exp_quiet();
        set_idle();
        tick(); exp_quiet();

        // One-sample read glitch: wait_n dips for the single SETTLE clk only.
        drive_bus(1'b1, 1'b0, 1'b0);
        addr = 16'h2000;
        tick(); exp_quiet(); e_wait_n = 1'b0;
        set_idle();
        for (int k = 0; k < 4; k++) begin
            tick(); exp_quiet();
        end

        // Non-qualifying patterns: INTA, foreign slot, RD+WR, MREQ+IORQ.
        ignored(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        ignored(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        ignored(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        ignored(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset asserted while a read sits in REQ.
        drive_bus(1'b1, 1'b0, 1'b0);
        addr = 16'h8123; din = 8'h44;
        for (int k = 0; k <= 4; k++) begin
            tick();
            e_req    = (k >= 3);
            e_wait_n = 1'b0;
            if (k == 3) begin
                e_req_wr = 1'b0; e_req_io = 1'b0;
                e_req_addr = 16'h8123; e_req_wdata = 8'h44;
            end
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async_req",    32'(req),      32'd0);
        check("rst_async_wait_n", 32'(wait_n),   32'd1);
        check("rst_async_addr",   32'(req_addr), 32'd0);
        check("rst_async_dout",   32'(dout),     32'd0);
        exp_reset();
        tick(); tick();
        reset_n = 1'b1;
        req_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (req) req_cycles++;
        end
        check("rst_no_reissue", 32'(req_cycles), 32'd0);
        set_idle();
        tick(); tick();

        // Recovery after reset.
        txn(1'b1, 1'b1, 16'h0099, 8'hC3, 2, 8'h00, 6, 1);
        check("recover_latency", 32'(rise_edge), 32'd3);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
